// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: instruction in, immediate out.
// Signal names match the block's external port list.
interface imm_extend_pipe_if #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             inValid;
  logic             inReady;
  logic [31:0]      inInstr;
  logic [2:0]       inImmType;
  logic [TAG_W-1:0] inTag;
  logic             outValid;
  logic             outReady;
  logic [XLEN-1:0]  outImm;
  logic [TAG_W-1:0] outTag;
  logic             outIllegal;
  logic [CW-1:0]    fifoCount;
  logic [7:0]       illegalCount;
  logic             clrIllegal;

  modport slave (
    input  inValid, inInstr, inImmType, inTag,
    input  outReady, clrIllegal,
    output inReady, outValid, outImm, outTag,
    output outIllegal, fifoCount, illegalCount
  );

  modport master (
    output inValid, inInstr, inImmType, inTag,
    output outReady, clrIllegal,
    input  inReady, outValid, outImm, outTag,
    input  outIllegal, fifoCount, illegalCount
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Elastic RV immediate extender with registered output FIFO.
// Optional CSR zimm / shift-amount codes via macro IMM_CSR_SHAMT_EN.
module imm_extend_pipe #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5
) (
  input logic               clk,
  input logic               rstN,
  imm_extend_pipe_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  entry_t        mem_q [FIFO_DEPTH];
  entry_t        in_e;
  entry_t        head;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ill_q, ill_d;
  logic          push, pop;
  logic [31:0]   ins;
  logic [2:0]    t;
  logic          unused_opc;

  assign ins = bus.inInstr;
  assign t   = bus.inImmType;
  assign unused_opc = ^ins[6:0];

  always_comb begin
    in_e     = '0;
    in_e.tag = bus.inTag;
    unique case (1'b1)
      (t == 3'd0): in_e.imm = XLEN'($signed(ins[31:20]));
      (t == 3'd1): in_e.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      (t == 3'd2): in_e.imm = XLEN'($signed({ins[31], ins[7],
                               ins[30:25], ins[11:8], 1'b0}));
      (t == 3'd3): in_e.imm = XLEN'($signed({ins[31], ins[19:12],
                               ins[20], ins[30:21], 1'b0}));
      (t == 3'd4): in_e.imm = XLEN'($signed({ins[31:12], 12'b0}));
`ifdef IMM_CSR_SHAMT_EN
      (t == 3'd5): in_e.imm = XLEN'(ins[19:15]);
      (t == 3'd6): in_e.imm = (XLEN == 64) ? XLEN'(ins[25:20])
                                           : XLEN'(ins[24:20]);
`endif
      default:     in_e.ill = 1'b1;
    endcase
  end

  // inReady comes only from the registered count, so a pop never
  // reopens the input in the same cycle.
  assign bus.inReady  = (cnt_q != CW'(FIFO_DEPTH));
  assign bus.outValid = (cnt_q != '0);
  assign push = bus.inValid && bus.inReady;
  assign pop  = bus.outValid && bus.outReady;

  assign head           = mem_q[rd_q];
  assign bus.outImm     = bus.outValid ? head.imm : '0;
  assign bus.outTag     = bus.outValid ? head.tag : '0;
  assign bus.outIllegal = bus.outValid && head.ill;
  assign bus.fifoCount    = cnt_q;
  assign bus.illegalCount = ill_q;

  always_comb begin
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    ill_d = ill_q;
    if (bus.clrIllegal)
      ill_d = '0;
    else if (push && in_e.ill && ill_q != 8'hFF)
      ill_d = ill_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ill_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ill_q <= ill_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= in_e;
    end
  end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (XLEN 32 and 64 instances).
// Reference model follows the immediate-format rules directly.
module tb_imm_extend_pipe;
  logic clk;
  logic rstN;
  int   tests;
  int   fails;

  imm_extend_pipe_if #(.XLEN(32), .FIFO_DEPTH(2), .TAG_W(5)) b32 ();
  imm_extend_pipe_if #(.XLEN(64), .FIFO_DEPTH(4), .TAG_W(5)) b64 ();

  imm_extend_pipe #(.XLEN(32), .FIFO_DEPTH(2), .TAG_W(5)) dut32 (
    .clk(clk), .rstN(rstN), .bus(b32));
  imm_extend_pipe #(.XLEN(64), .FIFO_DEPTH(4), .TAG_W(5)) dut64 (
    .clk(clk), .rstN(rstN), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  localparam logic [31:0] EXT_INS [4] =
    '{32'hFFF00093, 32'hFE512E23, 32'hFE000CE3, 32'h123450B7};
  localparam logic [2:0]  EXT_T   [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
  localparam logic [31:0] EXT_EXP [4] =
    '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000};

  function automatic void ref_imm(input logic [31:0] ins,
      input logic [2:0] t, input int xlen,
      output logic [63:0] imm, output logic ill);
    longint v;
    v   = 0;
    ill = 1'b0;
    case (t)
      3'd0: v = $signed(ins[31:20]);
      3'd1: v = $signed({ins[31:25], ins[11:7]});
      3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd3: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd4: v = $signed({ins[31:12], 12'h000});
`ifdef IMM_CSR_SHAMT_EN
      3'd5: v = ins[19:15];
      3'd6: v = (xlen == 64) ? ins[25:20] : ins[24:20];
`endif
      default: ill = 1'b1;
    endcase
    imm = (xlen == 32) ? {32'h0, v[31:0]} : 64'(v);
  endfunction

  task automatic idle_all();
    b32.inValid = 0; b32.outReady = 0; b32.clrIllegal = 0;
    b32.inInstr = 0; b32.inImmType = 0; b32.inTag = 0;
    b64.inValid = 0; b64.outReady = 0; b64.clrIllegal = 0;
    b64.inInstr = 0; b64.inImmType = 0; b64.inTag = 0;
  endtask

  task automatic test_reset();
    idle_all();
    rstN = 1'b0;
    @(negedge clk);
    tests++; if (b32.fifoCount !== 2'd0) begin fails++;
      $display("FAIL reset_count got %0d exp 0", b32.fifoCount); end
    tests++; if (b32.outValid !== 1'b0) begin fails++;
      $display("FAIL reset_outValid got %b exp 0", b32.outValid); end
    tests++; if (b32.outImm !== 32'h0 || b32.outTag !== 5'h0) begin fails++;
      $display("FAIL reset_head got %h/%h exp 0/0", b32.outImm, b32.outTag); end
    tests++; if (b32.outIllegal !== 1'b0) begin fails++;
      $display("FAIL reset_outIllegal got %b exp 0", b32.outIllegal); end
    tests++; if (b32.illegalCount !== 8'h0) begin fails++;
      $display("FAIL reset_illCount got %0d exp 0", b32.illegalCount); end
    tests++; if (b32.inReady !== 1'b1 || b64.inReady !== 1'b1) begin fails++;
      $display("FAIL reset_inReady got %b/%b exp 1/1", b32.inReady, b64.inReady); end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_extend();
    logic [63:0] e;
    logic        il;
    logic [31:0] ins;
    logic [2:0]  t;
    b32.outReady = 1;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        ins = EXT_INS[i]; t = EXT_T[i];
        e   = {32'h0, EXT_EXP[i]};
      end else begin
        ins = $urandom; t = 3'($urandom_range(0, 4));
        ref_imm(ins, t, 32, e, il);
      end
      b32.inValid = 1; b32.inInstr = ins;
      b32.inImmType = t; b32.inTag = 5'(i + 1);
      @(negedge clk);
      b32.inValid = 0;
      tests++; if (b32.outValid !== 1'b1 || b32.outIllegal !== 1'b0) begin
        fails++; $display("FAIL ext%0d_valid got v=%b il=%b exp 1/0",
          i, b32.outValid, b32.outIllegal); end
      tests++; if (b32.outImm !== e[31:0]) begin fails++;
        $display("FAIL ext%0d_imm type %0d instr %h got %h exp %h",
          i, t, ins, b32.outImm, e[31:0]); end
      tests++; if (b32.outTag !== 5'(i + 1)) begin fails++;
        $display("FAIL ext%0d_tag got %0d exp %0d", i, b32.outTag, i + 1); end
      @(negedge clk);
    end
    tests++; if (b32.outValid !== 1'b0) begin fails++;
      $display("FAIL ext_drain got %b exp 0", b32.outValid); end
  endtask

  task automatic test_xlen64();
    b64.outReady = 1;
    b64.inValid = 1; b64.inInstr = 32'h800000B7;
    b64.inImmType = 3'd4; b64.inTag = 5'd9;
    @(negedge clk);
    b64.inValid = 0;
    tests++; if (b64.outValid !== 1'b1 ||
                 b64.outImm !== 64'hFFFFFFFF80000000) begin fails++;
      $display("FAIL x64_lui got v=%b %h exp 1 ffffffff80000000",
        b64.outValid, b64.outImm); end
    @(negedge clk);
  endtask

  task automatic test_full();
    logic [31:0] ins [3];
    logic [63:0] e   [3];
    logic        il;
    b32.outReady = 0;
    for (int i = 0; i < 3; i++) begin
      ins[i] = $urandom;
      ref_imm(ins[i], 3'd0, 32, e[i], il);
    end
    for (int i = 0; i < 3; i++) begin
      b32.inValid = 1; b32.inInstr = ins[i];
      b32.inImmType = 3'd0; b32.inTag = 5'(20 + i);
      if (i < 2) @(negedge clk);
    end
    tests++; if (b32.inReady !== 1'b0 || b32.fifoCount !== 2'd2) begin
      fails++; $display("FAIL full_state got rdy=%b cnt=%0d exp 0/2",
        b32.inReady, b32.fifoCount); end
    tests++; if (b32.outImm !== e[0][31:0] || b32.outTag !== 5'd20) begin
      fails++; $display("FAIL full_head0 got %h/%0d exp %h/20",
        b32.outImm, b32.outTag, e[0][31:0]); end
    b32.outReady = 1;
    #1;
    tests++; if (b32.inReady !== 1'b0) begin fails++;
      $display("FAIL full_no_bypass got %b exp 0", b32.inReady); end
    @(negedge clk);
    tests++; if (b32.inReady !== 1'b1 || b32.fifoCount !== 2'd1) begin
      fails++; $display("FAIL full_reopen got rdy=%b cnt=%0d exp 1/1",
        b32.inReady, b32.fifoCount); end
    tests++; if (b32.outImm !== e[1][31:0] || b32.outTag !== 5'd21) begin
      fails++; $display("FAIL full_head1 got %h/%0d exp %h/21",
        b32.outImm, b32.outTag, e[1][31:0]); end
    @(negedge clk);
    b32.inValid = 0;
    tests++; if (b32.outImm !== e[2][31:0] || b32.outTag !== 5'd22 ||
                 b32.fifoCount !== 2'd1) begin fails++;
      $display("FAIL full_head2 got %h/%0d cnt=%0d exp %h/22/1",
        b32.outImm, b32.outTag, b32.fifoCount, e[2][31:0]); end
    @(negedge clk);
    tests++; if (b32.outValid !== 1'b0) begin fails++;
      $display("FAIL full_drain got %b exp 0", b32.outValid); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t x;
    logic [31:0] ins;
    logic [2:0]  t;
    b32.outReady = 1;
    for (int i = 0; i < 10; i++) begin
      if (q.size() != 0) begin
        tests++; if (b32.outImm !== q[0].imm[31:0] ||
                     b32.outTag !== q[0].tag ||
                     b32.fifoCount !== 2'd1) begin fails++;
          $display("FAIL b2b%0d got %h/%0d cnt=%0d exp %h/%0d/1", i,
            b32.outImm, b32.outTag, b32.fifoCount, q[0].imm[31:0], q[0].tag); end
        void'(q.pop_front());
      end
      if (i < 9) begin
        ins = $urandom; t = 3'($urandom_range(0, 4));
        ref_imm(ins, t, 32, x.imm, x.ill);
        x.tag = 5'($urandom);
        q.push_back(x);
        b32.inValid = 1; b32.inInstr = ins;
        b32.inImmType = t; b32.inTag = x.tag;
      end else b32.inValid = 0;
      @(negedge clk);
    end
    tests++; if (b32.outValid !== 1'b0) begin fails++;
      $display("FAIL b2b_drain got %b exp 0", b32.outValid); end
  endtask

  task automatic test_illegal();
    logic [2:0] codes [3];
`ifdef IMM_CSR_SHAMT_EN
    codes = '{3'd7, 3'd7, 3'd7};
`else
    codes = '{3'd5, 3'd6, 3'd7};
`endif
    b32.outReady = 1;
    b32.clrIllegal = 1;
    @(negedge clk);
    b32.clrIllegal = 0;
    for (int i = 0; i < 4; i++) begin
      b32.inValid = 1; b32.inInstr = $urandom;
      b32.inImmType = codes[i % 3]; b32.inTag = 5'(i);
      b32.clrIllegal = (i == 3);
      @(negedge clk);
      b32.inValid = 0; b32.clrIllegal = 0;
      tests++; if (b32.outValid !== 1'b1 || b32.outIllegal !== 1'b1 ||
                   b32.outImm !== 32'h0 || b32.outTag !== 5'(i)) begin
        fails++; $display("FAIL ill%0d got v=%b il=%b imm=%h tag=%0d exp 1/1/0/%0d",
          i, b32.outValid, b32.outIllegal, b32.outImm, b32.outTag, i); end
      if (i == 2) begin
        tests++; if (b32.illegalCount !== 8'd3) begin fails++;
          $display("FAIL ill_count got %0d exp 3", b32.illegalCount); end
      end
      if (i == 3) begin
        tests++; if (b32.illegalCount !== 8'd0) begin fails++;
          $display("FAIL ill_clr_prio got %0d exp 0", b32.illegalCount); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_csr();
    b32.outReady = 1;
    b32.inValid = 1; b32.inInstr = 32'h34015073;
    b32.inImmType = 3'd5; b32.inTag = 5'd3;
    @(negedge clk);
    b32.inValid = 0;
`ifdef IMM_CSR_SHAMT_EN
    tests++; if (b32.outImm !== 32'd2 || b32.outIllegal !== 1'b0) begin
      fails++; $display("FAIL csr_zimm got %h il=%b exp 2/0",
        b32.outImm, b32.outIllegal); end
`else
    tests++; if (b32.outImm !== 32'd0 || b32.outIllegal !== 1'b1) begin
      fails++; $display("FAIL csr_illegal got %h il=%b exp 0/1",
        b32.outImm, b32.outIllegal); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    b32.outReady = 0;
    b32.inValid = 1; b32.inInstr = $urandom;
    b32.inImmType = 3'd0; b32.inTag = 5'd7;
    @(negedge clk);
    b32.inValid = 0;
    tests++; if (b32.outValid !== 1'b1 || b32.fifoCount !== 2'd1) begin
      fails++; $display("FAIL rmid_pre got v=%b cnt=%0d exp 1/1",
        b32.outValid, b32.fifoCount); end
    #2 rstN = 1'b0;
    #1;
    tests++; if (b32.outValid !== 1'b0 || b32.fifoCount !== 2'd0 ||
                 b32.outImm !== 32'h0) begin fails++;
      $display("FAIL rmid_async got v=%b cnt=%0d imm=%h exp 0/0/0",
        b32.outValid, b32.fifoCount, b32.outImm); end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t x;
    int   mill;
    bit   stalled;
    bit   push, pop;
    mill = 0;
    stalled = 0;
    for (int c = 0; c < 600; c++) begin
      tests++; if (b64.outValid !== (q.size() != 0) ||
                   b64.fifoCount !== 3'(q.size()) ||
                   b64.inReady !== (q.size() != 4)) begin fails++;
        $display("FAIL rnd%0d_ctl got v=%b cnt=%0d rdy=%b exp size %0d",
          c, b64.outValid, b64.fifoCount, b64.inReady, q.size()); end
      tests++; if (b64.illegalCount !== 8'(mill)) begin fails++;
        $display("FAIL rnd%0d_illcnt got %0d exp %0d", c, b64.illegalCount, mill); end
      if (q.size() != 0) begin
        tests++; if (b64.outImm !== q[0].imm || b64.outTag !== q[0].tag ||
                     b64.outIllegal !== q[0].ill) begin fails++;
          $display("FAIL rnd%0d_head got %h/%0d/%b exp %h/%0d/%b", c,
            b64.outImm, b64.outTag, b64.outIllegal,
            q[0].imm, q[0].tag, q[0].ill); end
      end
      if (!stalled) begin
        b64.inValid = ($urandom_range(0, 3) != 0);
        b64.inInstr = $urandom;
        b64.inImmType = 3'($urandom);
        b64.inTag = 5'($urandom);
      end
      b64.outReady = ($urandom_range(0, 2) != 0);
      b64.clrIllegal = ($urandom_range(0, 40) == 0);
      push = b64.inValid && (q.size() != 4);
      pop  = b64.outReady && (q.size() != 0);
      stalled = b64.inValid && !push;
      ref_imm(b64.inInstr, b64.inImmType, 64, x.imm, x.ill);
      x.tag = b64.inTag;
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(x);
      if (b64.clrIllegal) mill = 0;
      else if (push && x.ill && mill < 255) mill++;
      @(negedge clk);
    end
    b64.inValid = 0; b64.clrIllegal = 0; b64.outReady = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_saturate();
    b64.outReady = 1;
    b64.clrIllegal = 1;
    @(negedge clk);
    b64.clrIllegal = 0;
    b64.inValid = 1; b64.inImmType = 3'd7;
    for (int i = 0; i < 260; i++) begin
      b64.inInstr = $urandom;
      b64.inTag = 5'(i);
      @(negedge clk);
      if (i == 253) begin
        tests++; if (b64.illegalCount !== 8'd254) begin fails++;
          $display("FAIL sat_254 got %0d exp 254", b64.illegalCount); end
      end
    end
    b64.inValid = 0;
    @(negedge clk);
    tests++; if (b64.illegalCount !== 8'd255) begin fails++;
      $display("FAIL sat_255 got %0d exp 255", b64.illegalCount); end
    b64.clrIllegal = 1;
    @(negedge clk);
    b64.clrIllegal = 0;
    tests++; if (b64.illegalCount !== 8'd0) begin fails++;
      $display("FAIL sat_clr got %0d exp 0", b64.illegalCount); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rstN  = 1'b0;
    idle_all();
    @(negedge clk);
    test_reset();
    test_extend();
    test_xlen64();
    test_full();
    test_back_to_back();
    test_illegal();
    test_csr();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
